// File: rtl/de1_soc_qsys_dac_player_if.sv
// Avalon-MM slave bus for the DAC player register file.
//   address    : register select (0 DATA, 1 CTRL, 2 DIV, 3 STATUS)
//   chipselect : slave select, qualifies writes
//   write_n    : active-low write strobe
//   writedata  : write data
//   readdata   : registered read data, one-cycle latency
interface de1_soc_qsys_dac_player_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport slave  (input address, chipselect, write_n, writedata, output readdata);
  modport master (output address, chipselect, write_n, writedata, input readdata);
endinterface

// File: rtl/de1_soc_qsys_dac_player.sv
// Sample buffer + rate divider driving an 8-bit DAC.
// Samples are written through DATA into a DEPTH-entry FIFO and played out
// on divider ticks, either streaming (pop per tick) or looping over the
// buffered entries without consuming them.
//   clk      : sole clock
//   reset_n  : asynchronous active-low reset
//   av       : Avalon-MM slave register port
//   out_port : current DAC sample
module de1_soc_qsys_dac_player #(
  parameter int DEPTH = 64
) (
  input  logic                      clk,
  input  logic                      reset_n,
  de1_soc_qsys_dac_player_if.slave  av,
  output logic [7:0]                out_port
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr, rptr, pptr;
  logic [AW:0]   count;
  logic          run, loop, underrun, overflow;
  logic [15:0]   div, div_cnt;

  logic wr, wr_data, wr_ctrl, wr_div, wr_stat, clr;
  logic full, empty, tick, play, pop, push, ovf_set, und_set;
  logic [AW-1:0] pp_eff, pp_adv, rptr_nxt, pptr_nxt;
  logic [AW:0]   pp_off, nxt_off;
  logic          pp_valid;
  logic [7:0]    sample;

  // upper half of writedata carries no register fields
  logic unused_wd;
  assign unused_wd = ^av.writedata[31:16];

  assign wr      = av.chipselect & ~av.write_n;
  assign wr_data = wr && (av.address == 2'd0);
  assign wr_ctrl = wr && (av.address == 2'd1);
  assign wr_div  = wr && (av.address == 2'd2);
  assign wr_stat = wr && (av.address == 2'd3);
  assign clr     = wr_ctrl && av.writedata[2];

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign tick  = run && (div_cnt == div);

  // a clear wins over anything the tick would do on the same edge
  assign play    = tick && !empty && !clr;
  assign pop     = play && !loop;
  assign push    = wr_data && (!full || pop);
  assign ovf_set = wr_data && full && !pop;
  assign und_set = tick && empty && !clr;

  // play pointer falls back to the head whenever it points past the newest entry
  always_comb begin
    pp_off   = (AW+1)'(AW'(pptr - rptr));
    pp_valid = pp_off < count;
    pp_eff   = pp_valid ? pptr : rptr;
    nxt_off  = (pp_valid ? pp_off : '0) + 1'b1;
    pp_adv   = (nxt_off >= count) ? rptr : AW'(pp_eff + 1'b1);
    rptr_nxt = pop ? AW'(rptr + 1'b1) : rptr;
    sample   = loop ? mem[pp_eff] : mem[rptr];
  end

  always_comb begin
    pptr_nxt = pptr;
    if (clr)                                        pptr_nxt = '0;
    else if (wr_ctrl && av.writedata[1] && !loop)   pptr_nxt = rptr_nxt;
    else if (play && loop)                          pptr_nxt = pp_adv;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= av.writedata[7:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run      <= 1'b0;
      loop     <= 1'b0;
      div      <= '0;
      div_cnt  <= '0;
      wptr     <= '0;
      rptr     <= '0;
      pptr     <= '0;
      count    <= '0;
      underrun <= 1'b0;
      overflow <= 1'b0;
      out_port <= '0;
    end else begin
      if (!run || tick) div_cnt <= '0;
      else              div_cnt <= div_cnt + 1'b1;

      if (wr_div) div <= av.writedata[15:0];

      if (wr_ctrl) begin
        run  <= av.writedata[0];
        loop <= av.writedata[1];
      end

      pptr <= pptr_nxt;
      if (play) out_port <= sample;

      if (clr) begin
        wptr     <= '0;
        rptr     <= '0;
        count    <= '0;
        underrun <= 1'b0;
        overflow <= 1'b0;
      end else begin
        if (push) wptr <= AW'(wptr + 1'b1);
        rptr <= rptr_nxt;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
        // a sticky set on the same edge beats its write-1-to-clear
        if (und_set)                         underrun <= 1'b1;
        else if (wr_stat && av.writedata[11]) underrun <= 1'b0;
        if (ovf_set)                         overflow <= 1'b1;
        else if (wr_stat && av.writedata[12]) overflow <= 1'b0;
      end
    end
  end

  // read mux sampled every clock regardless of chipselect
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) av.readdata <= '0;
    else begin
      case (av.address)
        2'd0:    av.readdata <= {24'd0, out_port};
        2'd1:    av.readdata <= {30'd0, run, loop};   // run in bit1, loop in bit0
        2'd2:    av.readdata <= {16'd0, div};
        default: av.readdata <= {19'd0, overflow, underrun, full, empty, 9'(count)};
      endcase
    end
  end
endmodule

// File: tb/tb_de1_soc_qsys_dac_player.sv
module tb_de1_soc_qsys_dac_player;
  localparam int DEPTH = 16;
  localparam logic [31:0] EMPTY = 32'h200, FULLB = 32'h400, UND = 32'h800, OVF = 32'h1000;

  logic clk = 1'b0, reset_n = 1'b0;
  logic [7:0] out_port;
  de1_soc_qsys_dac_player_if av();

  de1_soc_qsys_dac_player #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .av(av), .out_port(out_port));

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0, cyc = 0;
  logic [7:0] sb [$];
  int chg_cyc [$];
  logic [7:0] prev = 8'h00;
  logic mon_en = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // scoreboard: every out_port change must match the next expected sample
  always @(negedge clk) begin
    if (mon_en && out_port !== prev) begin
      if (sb.size() == 0) chk("unexpected_out", {24'd0, out_port}, {24'd0, prev});
      else chk("sample", {24'd0, out_port}, {24'd0, sb.pop_front()});
      chg_cyc.push_back(cyc);
      prev = out_port;
    end
  end

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    av.address = a; av.writedata = d; av.chipselect = 1'b1; av.write_n = 1'b0;
    @(negedge clk);
    av.chipselect = 1'b0; av.write_n = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    av.address = a;
    @(negedge clk);
    d = av.readdata;
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] d;
    rd(a, d);
    chk(tag, d, exp);
  endtask

  task automatic wait_drain(input int max);
    int n = 0;
    while (sb.size() != 0 && n < max) begin
      @(negedge clk);
      n++;
    end
    chk("drain", sb.size(), 0);
  endtask

  initial begin
    int cw;
    av.address = 2'd0; av.chipselect = 1'b0; av.write_n = 1'b1; av.writedata = '0;
    #3;
    chk("rst_readdata", av.readdata, 0);
    chk("rst_out", {24'd0, out_port}, 0);
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    rd_chk("rst_status", 2'd3, EMPTY);
    rd_chk("rst_ctrl", 2'd1, 0);
    rd_chk("rst_div", 2'd2, 0);
    rd_chk("rst_data", 2'd0, 0);

    // streaming at DIV=3
    wr(2'd2, 3);
    rd_chk("div3", 2'd2, 3);
    foreach (sb[i]) ;
    wr(2'd0, 32'h11); sb.push_back(8'h11);
    wr(2'd0, 32'h22); sb.push_back(8'h22);
    wr(2'd0, 32'h33); sb.push_back(8'h33);
    rd_chk("cnt3", 2'd3, 3);
    chg_cyc.delete();
    wr(2'd1, 1);
    cw = cyc;
    rd_chk("ctrl_run", 2'd1, 2);
    wait_drain(40);
    if (chg_cyc.size() == 3) begin
      chk("first_tick", chg_cyc[0] - cw, 4);
      chk("spacing1", chg_cyc[1] - chg_cyc[0], 4);
      chk("spacing2", chg_cyc[2] - chg_cyc[1], 4);
    end else chk("stream_changes", chg_cyc.size(), 3);
    repeat (6) @(negedge clk);
    rd_chk("stream_status", 2'd3, EMPTY | UND);
    rd_chk("stream_last", 2'd0, 32'h33);
    wr(2'd1, 0);
    wr(2'd1, 4);

    // overflow: DEPTH+1 pushes, extra one never played
    for (int i = 0; i <= DEPTH; i++) begin
      wr(2'd0, 32'h40 + i);
      if (i < DEPTH) sb.push_back(8'(8'h40 + i));
    end
    rd_chk("ovf_status", 2'd3, DEPTH | FULLB | OVF);
    wr(2'd2, 0);
    wr(2'd1, 1);
    wait_drain(60);
    repeat (4) @(negedge clk);
    rd_chk("ovf_drained", 2'd3, EMPTY | UND | OVF);
    chk("ovf_last", {24'd0, out_port}, 32'h4F);
    wr(2'd1, 0);
    wr(2'd1, 4);

    // loop mode, DIV=0
    wr(2'd0, 32'hA0);
    wr(2'd0, 32'hA1);
    for (int i = 0; i < 4; i++) begin sb.push_back(8'hA0); sb.push_back(8'hA1); end
    chg_cyc.delete();
    wr(2'd1, 3);
    repeat (3) @(negedge clk);
    wr(2'd1, 2);
    repeat (4) @(negedge clk);
    chk("loop_changes", chg_cyc.size(), 4);
    if (chg_cyc.size() >= 4)
      for (int i = 1; i < 4; i++) chk("loop_spacing", chg_cyc[i] - chg_cyc[i-1], 1);
    rd_chk("loop_status", 2'd3, 2);
    rd_chk("loop_ctrl", 2'd1, 1);
    sb.delete();
    wr(2'd1, 4);

    // push and pop on the same edge while full
    for (int i = 0; i < DEPTH; i++) begin
      wr(2'd0, 32'h60 + i); sb.push_back(8'(8'h60 + i));
    end
    wr(2'd1, 1);
    wr(2'd0, 32'h7F); sb.push_back(8'h7F);
    rd_chk("full_pushpop", 2'd3, DEPTH | FULLB);
    wait_drain(60);
    repeat (3) @(negedge clk);
    rd_chk("full_drained", 2'd3, EMPTY | UND);
    wr(2'd1, 0);

    // clear during playback, sticky flag clearing
    wr(2'd1, 4);
    wr(2'd2, 3);
    wr(2'd0, 32'h81); sb.push_back(8'h81);
    wr(2'd0, 32'h82);
    wr(2'd0, 32'h83);
    wr(2'd1, 1);
    wait_drain(20);
    wr(2'd1, 4);
    rd_chk("clr_status", 2'd3, EMPTY);
    chk("clr_out_held", {24'd0, out_port}, 32'h81);
    rd_chk("clr_ctrl", 2'd1, 0);
    wr(2'd2, 0);
    wr(2'd1, 1);
    wr(2'd3, 32'h800);
    rd_chk("set_beats_clr", 2'd3, EMPTY | UND);
    wr(2'd1, 0);
    for (int i = 0; i <= DEPTH; i++) wr(2'd0, 32'hC0 + i);
    rd_chk("both_flags", 2'd3, DEPTH | FULLB | UND | OVF);
    wr(2'd3, 32'h800);
    rd_chk("und_cleared", 2'd3, DEPTH | FULLB | OVF);
    wr(2'd1, 4);
    rd_chk("after_clr", 2'd3, EMPTY);

    // reset mid-playback
    wr(2'd2, 1);
    wr(2'd0, 32'h91); sb.push_back(8'h91);
    wr(2'd0, 32'h92);
    wr(2'd0, 32'h93);
    wr(2'd1, 1);
    wait_drain(20);
    mon_en = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_out", {24'd0, out_port}, 0);
    chk("mid_rst_rd", av.readdata, 0);
    @(negedge clk);
    reset_n = 1'b1;
    prev = 8'h00;
    mon_en = 1'b1;
    repeat (10) @(negedge clk);
    chk("post_rst_out", {24'd0, out_port}, 0);
    rd_chk("post_rst_status", 2'd3, EMPTY);
    rd_chk("post_rst_ctrl", 2'd1, 0);
    wr(2'd0, 32'hB1); sb.push_back(8'hB1);
    wr(2'd1, 1);
    wait_drain(20);
    rd_chk("post_rst_play", 2'd0, 32'hB1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
